oc_pair_launch: RTL and testbench
=================================

Name: oc_pair_launch

Overview:
- Downstream consumer of two operand_collector instances (operand A and operand B) for one functional-unit pipeline.
- Holds per-instruction op info in an in-order FIFO, written at issue time. Each FIFO entry matches one A/B collector entry pair.
- When the head op has both operands collected, the block acks both collectors and registers op info plus both 32-bit operands into a launch register.
- The launch register has a valid/ready handshake to the execution pipeline.

Parameters:
- OC_ENTRIES, 3, depth of the op-info FIFO; must equal OC_ENTRIES of both attached operand collectors.
- LOG_OC_ENTRIES, $clog2(OC_ENTRIES), FIFO pointer width.
- INFO_WIDTH, 18, width of the opaque per-op info bundle (op, dest PR, ROB tag packed by the issue queue).

Ports:
- CLK  in  1  clock
- nRST  in  1  reset; asynchronous, active-low
- issue_valid  in  1  op issued this cycle; the same cycle enqueues into both collectors
- issue_info  in  INFO_WIDTH  op info for the issued op
- issue_ready  out  1  FIFO not full
- A_operand_collected  in  1  head of collector A has data
- A_operand_collected_ack  out  1  pop collected status of A
- A_operand_data  in  32  head data of collector A
- A_operand_data_ack  out  1  pop data of A
- B_operand_collected, B_operand_collected_ack, B_operand_data, B_operand_data_ack  same as A for operand B
- launch_valid  out  1  launch register valid
- launch_info  out  INFO_WIDTH  launched op info
- launch_A  out  32  operand A
- launch_B  out  32  operand B
- launch_ready  in  1  pipeline accepts launch this cycle

Behaviour:
- Reset: FIFO empty (head = tail = 0, count = 0). launch_valid = 0, launch_info = 0, launch_A = 0, launch_B = 0. All ack outputs = 0. issue_ready = 1. Reset asserted mid-operation discards all FIFO and launch contents immediately.
- FIFO:
  - Circular, depth OC_ENTRIES; pointers wrap from OC_ENTRIES-1 to 0 (non-power-of-2 is legal).
  - count has width LOG_OC_ENTRIES+1.
  - issue_ready = (count != OC_ENTRIES); it is combinational from registered count only and does not reflect a pop in the same cycle.
  - issue_valid while full: the op is dropped, FIFO state is unchanged; the SVA flags an error.
- Launch-stage-free: launch_free = ~launch_valid | launch_ready.
- Fire condition (combinational): fire = (count != 0) & A_operand_collected & B_operand_collected & launch_free.
- On fire:
  - All four ack outputs = 1 in the same cycle. Acks are combinational, 0 otherwise, and A and B are never acked separately.
  - Next edge: launch_valid <= 1; launch_info <= FIFO[head]; launch_A <= A_operand_data; launch_B <= B_operand_data; head advances; count decrements.
- No fire and launch_ready = 1: launch_valid <= 0; data fields hold.
- No fire and launch_ready = 0: launch register holds (stall).
- Latency: operands collected at cycle N with launch stage free, so launch_valid = 1 at N+1. Sustained throughput is 1 op per cycle.
- Simultaneous issue and fire: count unchanged; tail and head both advance. Issue and fire with count = OC_ENTRIES: fire proceeds but issue is dropped, because issue_ready was 0.
- Operand collected with FIFO empty: no fire, no ack. This is a protocol error and is flagged by SVA.
- Ordering: strictly in order; the head op blocks younger ops even if their operands are ready.

Optional Feature:
- Macro OC_PAIR_LAUNCH_PERF_EN.
- Defined: adds three 32-bit saturating counter outputs, reset 0:
  - perf_wait_A_cycles: count != 0 & ~A_collected.
  - perf_wait_B_cycles: count != 0 & A_collected & ~B_collected.
  - perf_stall_cycles: launch_valid & ~launch_ready.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- core_types_pkg: add typedef oc_launch_info_t (packed, INFO_WIDTH bits) and localparam OC_PAIR_INFO_WIDTH = 18.
- Sub-module oc_info_fifo holds the parameterized circular FIFO: enq, deq, full, empty, head data, count.
- The fire logic and launch register live in the top module.

Test Plan:
- Reset, then issue info 0x155 with A = 0xDEADBEEF and B = 0x12345678 collected the cycle after issue, launch_ready = 1 -> acks pulse in that cycle; launch_valid = 1 the next cycle with info 0x155, A 0xDEADBEEF, B 0x12345678.
- Issue 3 ops with no operands collected -> issue_ready = 0 after the third; a 4th issue is dropped and the SVA fires. Collect A/B for the head -> one fire, issue_ready = 1 next cycle.
- A collected, B held low for 5 cycles -> no ack and launch_valid stays 0; B rises -> fire and launch the next cycle.
- Two ops ready back-to-back, launch_ready = 0 for 4 cycles -> first launch holds its values, second is not acked; launch_ready = 1 -> second fires the same cycle, and its launch is visible the next cycle.
- Fill/drain over 10 ops with issue and fire each cycle -> count stays constant, pointers wrap 2→0, launched infos appear in issue order.
- nRST asserted while launch_valid = 1 and count = 2 -> all outputs 0 immediately; after release, issue_ready = 1 and there are no spurious launches.

Source files
------------

// File: rtl/core_types_pkg.sv
// Shared core types for the operand-collector launch path.
// Info bundle typedef and its default width.
package core_types_pkg;

    localparam int OC_PAIR_INFO_WIDTH = 18;

    typedef logic [OC_PAIR_INFO_WIDTH-1:0] oc_launch_info_t;

endpackage

// File: rtl/oc_info_fifo.sv
// In-order circular FIFO of per-op info; any depth, pointers wrap at DEPTH-1.
module oc_info_fifo #(
    parameter int DEPTH     = 3,
    parameter int LOG_DEPTH = $clog2(DEPTH),
    parameter int W         = 18
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         enq,
    input  logic [W-1:0] enq_data,
    input  logic         deq,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head_data
);

    logic [W-1:0]         mem_q [DEPTH];
    logic [W-1:0]         mem_d [DEPTH];
    logic [LOG_DEPTH-1:0] head_q, head_d;
    logic [LOG_DEPTH-1:0] tail_q, tail_d;
    logic [LOG_DEPTH:0]   count_q, count_d;
    logic                 enq_ok, deq_ok;

    function automatic logic [LOG_DEPTH-1:0] wrap_inc(input logic [LOG_DEPTH-1:0] p);
        return (p == LOG_DEPTH'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (count_q == (LOG_DEPTH + 1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign head_data = mem_q[head_q];
    assign enq_ok    = enq & ~full;
    assign deq_ok    = deq & ~empty;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (enq_ok) begin
            mem_d[tail_q] = enq_data;
            tail_d        = wrap_inc(tail_q);
        end
        if (deq_ok) begin
            head_d = wrap_inc(head_q);
        end
        unique case ({enq_ok, deq_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/oc_pair_launch.sv
// Pairs A/B operand-collector heads with in-order op info into a launch register.
// Optional OC_PAIR_LAUNCH_PERF_EN adds saturating wait/stall counters.
module oc_pair_launch
    import core_types_pkg::*;
#(
    parameter int OC_ENTRIES     = 3,
    parameter int LOG_OC_ENTRIES = $clog2(OC_ENTRIES),
    parameter int INFO_WIDTH     = $bits(oc_launch_info_t)
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  issue_valid,
    input  logic [INFO_WIDTH-1:0] issue_info,
    output logic                  issue_ready,
    input  logic                  A_operand_collected,
    output logic                  A_operand_collected_ack,
    input  logic [31:0]           A_operand_data,
    output logic                  A_operand_data_ack,
    input  logic                  B_operand_collected,
    output logic                  B_operand_collected_ack,
    input  logic [31:0]           B_operand_data,
    output logic                  B_operand_data_ack,
    output logic                  launch_valid,
    output logic [INFO_WIDTH-1:0] launch_info,
    output logic [31:0]           launch_A,
    output logic [31:0]           launch_B,
`ifdef OC_PAIR_LAUNCH_PERF_EN
    output logic [31:0]           perf_wait_A_cycles,
    output logic [31:0]           perf_wait_B_cycles,
    output logic [31:0]           perf_stall_cycles,
`endif
    input  logic                  launch_ready
);

    logic                  fifo_full, fifo_empty;
    logic [INFO_WIDTH-1:0] head_info;
    logic                  launch_free, fire;

    logic                  launch_valid_q, launch_valid_d;
    logic [INFO_WIDTH-1:0] launch_info_q, launch_info_d;
    logic [31:0]           launch_a_q, launch_a_d;
    logic [31:0]           launch_b_q, launch_b_d;

    oc_info_fifo #(
        .DEPTH     (OC_ENTRIES),
        .LOG_DEPTH (LOG_OC_ENTRIES),
        .W         (INFO_WIDTH)
    ) u_fifo (
        .CLK       (CLK),
        .nRST      (nRST),
        .enq       (issue_valid),
        .enq_data  (issue_info),
        .deq       (fire),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (head_info)
    );

    assign issue_ready = ~fifo_full;
    assign launch_free = ~launch_valid_q | launch_ready;
    assign fire = ~fifo_empty & A_operand_collected
                & B_operand_collected & launch_free;

    // Both collectors always pop together so their entries stay paired.
    assign A_operand_collected_ack = fire;
    assign A_operand_data_ack      = fire;
    assign B_operand_collected_ack = fire;
    assign B_operand_data_ack      = fire;

    always_comb begin
        launch_valid_d = launch_valid_q;
        launch_info_d  = launch_info_q;
        launch_a_d     = launch_a_q;
        launch_b_d     = launch_b_q;
        if (fire) begin
            launch_valid_d = 1'b1;
            launch_info_d  = head_info;
            launch_a_d     = A_operand_data;
            launch_b_d     = B_operand_data;
        end else if (launch_ready) begin
            launch_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            launch_valid_q <= 1'b0;
            launch_info_q  <= '0;
            launch_a_q     <= '0;
            launch_b_q     <= '0;
        end else begin
            launch_valid_q <= launch_valid_d;
            launch_info_q  <= launch_info_d;
            launch_a_q     <= launch_a_d;
            launch_b_q     <= launch_b_d;
        end
    end

    assign launch_valid = launch_valid_q;
    assign launch_info  = launch_info_q;
    assign launch_A     = launch_a_q;
    assign launch_B     = launch_b_q;

`ifdef OC_PAIR_LAUNCH_PERF_EN
    logic [31:0] perf_wait_a_q, perf_wait_a_d;
    logic [31:0] perf_wait_b_q, perf_wait_b_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic        wait_a, wait_b, stall;

    assign wait_a = ~fifo_empty & ~A_operand_collected;
    assign wait_b = ~fifo_empty & A_operand_collected & ~B_operand_collected;
    assign stall  = launch_valid_q & ~launch_ready;

    always_comb begin
        perf_wait_a_d = perf_wait_a_q;
        perf_wait_b_d = perf_wait_b_q;
        perf_stall_d  = perf_stall_q;
        if (wait_a && ~&perf_wait_a_q) perf_wait_a_d = perf_wait_a_q + 32'd1;
        if (wait_b && ~&perf_wait_b_q) perf_wait_b_d = perf_wait_b_q + 32'd1;
        if (stall && ~&perf_stall_q)   perf_stall_d  = perf_stall_q + 32'd1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            perf_wait_a_q <= '0;
            perf_wait_b_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_wait_a_q <= perf_wait_a_d;
            perf_wait_b_q <= perf_wait_b_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_wait_A_cycles = perf_wait_a_q;
    assign perf_wait_B_cycles = perf_wait_b_q;
    assign perf_stall_cycles  = perf_stall_q;
`endif

    a_issue_not_full: assert property (@(posedge CLK) disable iff (!nRST)
        issue_valid |-> issue_ready)
        else $error("issue_valid while FIFO full; op dropped");

    a_collect_has_op: assert property (@(posedge CLK) disable iff (!nRST)
        (A_operand_collected | B_operand_collected) |-> ~fifo_empty)
        else $error("operand collected with empty op FIFO");

endmodule

// File: tb/tb_oc_pair_launch.sv
// Scoreboard bench for oc_pair_launch: driver runs a queue-based op model,
// monitor checks acks/ready/valid each cycle and launched ops at handshake.
module tb_oc_pair_launch;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        issue_valid = 1'b0;
    logic [17:0] issue_info = '0;
    logic        issue_ready;
    logic        A_operand_collected = 1'b0;
    logic        A_operand_collected_ack;
    logic [31:0] A_operand_data = '0;
    logic        A_operand_data_ack;
    logic        B_operand_collected = 1'b0;
    logic        B_operand_collected_ack;
    logic [31:0] B_operand_data = '0;
    logic        B_operand_data_ack;
    logic        launch_valid;
    logic [17:0] launch_info;
    logic [31:0] launch_A;
    logic [31:0] launch_B;
    logic        launch_ready = 1'b0;
`ifdef OC_PAIR_LAUNCH_PERF_EN
    logic [31:0] perf_wait_A_cycles, perf_wait_B_cycles, perf_stall_cycles;
`endif

    oc_pair_launch dut (
        .CLK                     (CLK),
        .nRST                    (nRST),
        .issue_valid             (issue_valid),
        .issue_info              (issue_info),
        .issue_ready             (issue_ready),
        .A_operand_collected     (A_operand_collected),
        .A_operand_collected_ack (A_operand_collected_ack),
        .A_operand_data          (A_operand_data),
        .A_operand_data_ack      (A_operand_data_ack),
        .B_operand_collected     (B_operand_collected),
        .B_operand_collected_ack (B_operand_collected_ack),
        .B_operand_data          (B_operand_data),
        .B_operand_data_ack      (B_operand_data_ack),
        .launch_valid            (launch_valid),
        .launch_info             (launch_info),
        .launch_A                (launch_A),
        .launch_B                (launch_B),
`ifdef OC_PAIR_LAUNCH_PERF_EN
        .perf_wait_A_cycles      (perf_wait_A_cycles),
        .perf_wait_B_cycles      (perf_wait_B_cycles),
        .perf_stall_cycles       (perf_stall_cycles),
`endif
        .launch_ready            (launch_ready)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [17:0] info;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    typedef struct {
        bit ir;
        bit ack;
        bit lv;
    } chk_t;

    localparam int DEPTH = 3;

    op_t  ops[$];
    op_t  exp_q[$];
    chk_t chk_q[$];
    bit   lv_m = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus plus the reference model's view of that cycle.
    task automatic step(input bit iv, input logic [17:0] info,
                        input logic [31:0] a, input logic [31:0] b,
                        input bit ca, input bit cb, input bit lr);
        op_t  n;
        chk_t c;
        bit   f;
        @(posedge CLK);
        #1;
        if (ops.size() == 0) begin
            ca = 1'b0;
            cb = 1'b0;
        end
        if (ops.size() == DEPTH) iv = 1'b0;
        issue_valid         = iv;
        issue_info          = info;
        A_operand_collected = ca;
        B_operand_collected = cb;
        A_operand_data      = (ops.size() != 0) ? ops[0].a : $urandom;
        B_operand_data      = (ops.size() != 0) ? ops[0].b : $urandom;
        launch_ready        = lr;
        f = (ops.size() != 0) && ca && cb && (!lv_m || lr);
        c.ir  = (ops.size() != DEPTH);
        c.ack = f;
        c.lv  = lv_m;
        chk_q.push_back(c);
        if (f) begin
            exp_q.push_back(ops.pop_front());
            lv_m = 1'b1;
        end else if (lr) begin
            lv_m = 1'b0;
        end
        if (iv) begin
            n.info = info;
            n.a    = a;
            n.b    = b;
            ops.push_back(n);
        end
    endtask

    task automatic idle(input bit lr);
        step(1'b0, '0, '0, '0, 1'b0, 1'b0, lr);
    endtask

    task automatic issue_only(input logic [17:0] info);
        step(1'b1, info, $urandom, $urandom, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 64'(launch_valid), 64'd0);
        check({tag, "_info"}, 64'(launch_info), 64'd0);
        check({tag, "_A"}, 64'(launch_A), 64'd0);
        check({tag, "_B"}, 64'(launch_B), 64'd0);
        check({tag, "_acks"}, 64'({A_operand_collected_ack, A_operand_data_ack,
               B_operand_collected_ack, B_operand_data_ack}), 64'd0);
        check({tag, "_issue_ready"}, 64'(issue_ready), 64'd1);
    endtask

    // Monitor: per-cycle control checks and handshake scoreboard.
    initial begin
        chk_t c;
        op_t  e;
        forever begin
            @(negedge CLK);
            if (chk_q.size() != 0) begin
                c = chk_q.pop_front();
                check("issue_ready", 64'(issue_ready), 64'(c.ir));
                check("acks", 64'({A_operand_collected_ack, A_operand_data_ack,
                       B_operand_collected_ack, B_operand_data_ack}), {60'd0, {4{c.ack}}});
                check("launch_valid", 64'(launch_valid), 64'(c.lv));
            end
            if (nRST && launch_valid && launch_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_launch", 64'(launch_info), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("launch_info", 64'(launch_info), 64'(e.info));
                    check("launch_A", 64'(launch_A), 64'(e.a));
                    check("launch_B", 64'(launch_B), 64'(e.b));
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        #2;
        check_reset_outputs("rst");
        #20;
        @(negedge CLK);
        nRST = 1'b1;

        // Single op: collected the cycle after issue, launched the next.
        step(1'b1, 18'h155, 32'hDEADBEEF, 32'h12345678, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b1);
        repeat (2) idle(1'b1);

        // Fill to full; the extra issue is withheld since issue_ready is 0.
        issue_only(18'h001);
        issue_only(18'h002);
        issue_only(18'h003);
        issue_only(18'h004);
        step(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        repeat (3) step(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b1);
        idle(1'b1);

        // A ready, B withheld for 5 cycles.
        issue_only(18'h0AA);
        repeat (5) step(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
        step(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b1);
        repeat (2) idle(1'b1);

        // Back-to-back ready ops with a 4-cycle downstream stall.
        issue_only(18'h0B1);
        issue_only(18'h0B2);
        step(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b0);
        repeat (4) step(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b1);
        repeat (2) idle(1'b1);

        // Sustained issue+fire for 10 ops with two ops resident.
        issue_only(18'h100);
        issue_only(18'h101);
        for (int i = 0; i < 10; i++)
            step(1'b1, 18'(18'h200 + i), $urandom, $urandom, 1'b1, 1'b1, 1'b1);
        repeat (4) step(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b1);
        idle(1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 18'($urandom), $urandom, $urandom,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0);
        repeat (8) step(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b1);
        idle(1'b1);

        // Reset mid-operation with launch_valid=1 and two ops queued.
        issue_only(18'h301);
        issue_only(18'h302);
        issue_only(18'h303);
        step(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b0);
        @(negedge CLK);
        #1;
        nRST                = 1'b0;
        issue_valid         = 1'b0;
        A_operand_collected = 1'b0;
        B_operand_collected = 1'b0;
        launch_ready        = 1'b0;
        #1;
        check_reset_outputs("midrst");
        ops.delete();
        exp_q.delete();
        lv_m = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        repeat (4) idle(1'b1);
        step(1'b1, 18'h3FF, 32'hCAFEF00D, 32'h0BADC0DE, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b1);
        repeat (3) idle(1'b1);

        @(negedge CLK);
        #1;
        check("pending_launches", 64'(exp_q.size()), 64'd0);
        check("pending_ops", 64'(ops.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
